// File: rtl/reg_writer_if.sv
// Write-request channel for reg_writer: valid/ready handshake carrying a register index and data.
interface reg_writer_if;
    logic        wvalid;
    logic        wready;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    modport master (output wvalid, output waddr, output wdata, input wready);
    modport slave  (input wvalid, input waddr, input wdata, output wready);
endinterface

// File: rtl/reg_writer.sv
// 32x32 register array fed through a 2-entry in-order write buffer; register 0 is hardwired to zero.
// Optional macro REG_WRITER_BYPASS_EN: writes accepted while the buffer is empty commit on the accept edge.
module reg_writer (
    input  logic            clk,
    input  logic            rst_n,
    reg_writer_if.slave     wr,
    input  logic            flush,
    output logic [1023:0]   regs_flat,
    output logic [1:0]      pending,
    output logic [15:0]     commit_cnt
);
    logic [4:0]  fifo_addr [2];
    logic [31:0] fifo_data [2];
    logic        head;
    logic [1:0]  count;
    logic [31:0] regs [1:31];

    logic        push;
    logic        pop;
    logic        bypass;
    logic        fifo_push;
    logic        tail;
    logic        commit_en;
    logic [4:0]  commit_addr;
    logic [31:0] commit_data;

    assign wr.wready = (count < 2'd2);
    assign pending   = count;

    assign push = wr.wvalid && wr.wready && !flush;
    assign pop  = (count != 2'd0) && !flush;
`ifdef REG_WRITER_BYPASS_EN
    assign bypass = push && (count == 2'd0);
`else
    assign bypass = 1'b0;
`endif
    assign fifo_push = push && !bypass;
    assign tail      = head ^ count[0];

    // Head entry takes priority; bypass only occurs when the buffer is empty so they never collide.
    always_comb begin
        commit_en   = 1'b0;
        commit_addr = '0;
        commit_data = '0;
        if (pop) begin
            commit_en   = 1'b1;
            commit_addr = fifo_addr[head];
            commit_data = fifo_data[head];
        end else if (bypass) begin
            commit_en   = 1'b1;
            commit_addr = wr.waddr;
            commit_data = wr.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            count <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (fifo_push) begin
                fifo_addr[tail] <= wr.waddr;
                fifo_data[tail] <= wr.wdata;
            end
            if (pop)
                head <= ~head;
            count <= count + {1'b0, fifo_push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_cnt <= '0;
            for (int unsigned i = 1; i < 32; i++)
                regs[i] <= '0;
        end else if (commit_en && (commit_addr != 5'd0)) begin
            regs[commit_addr] <= commit_data;
            commit_cnt        <= commit_cnt + 16'd1;
        end
    end

    always_comb begin
        regs_flat[31:0] = '0;
        for (int unsigned i = 1; i < 32; i++)
            regs_flat[32*i +: 32] = regs[i];
    end
endmodule

// File: tb/tb_reg_writer.sv
// Directed self-checking bench for reg_writer; expectations follow REG_WRITER_BYPASS_EN when defined.
module tb_reg_writer;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [1023:0] regs_flat;
    logic [1:0]    pending;
    logic [15:0]   commit_cnt;
    int            checks = 0;
    int            passed = 0;

`ifdef REG_WRITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_writer_if bus ();

    reg_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr         (bus),
        .flush      (flush),
        .regs_flat  (regs_flat),
        .pending    (pending),
        .commit_cnt (commit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rg(input int i);
        return regs_flat[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.wvalid = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        tick();
        checks++; if (regs_flat !== '0) $display("FAIL reset_regs got %h exp 0", regs_flat[63:0]); else passed++;
        checks++; if (pending !== 2'd0) $display("FAIL reset_pending got %0d exp 0", pending); else passed++;
        checks++; if (commit_cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", commit_cnt); else passed++;
        checks++; if (bus.wready !== 1'b1) $display("FAIL reset_wready got %b exp 1", bus.wready); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        bus.wvalid = 1'b1; bus.waddr = 5'd5; bus.wdata = 32'hDEADBEEF;
        tick();
        bus.wvalid = 1'b0;
        checks++; if (rg(5) !== (BYP ? 32'hDEADBEEF : 32'h0)) $display("FAIL single_edge1 got %h exp %h", rg(5), BYP ? 32'hDEADBEEF : 32'h0); else passed++;
        checks++; if (pending !== (BYP ? 2'd0 : 2'd1)) $display("FAIL single_pending got %0d exp %0d", pending, BYP ? 0 : 1); else passed++;
        tick();
        checks++; if (rg(5) !== 32'hDEADBEEF) $display("FAIL single_edge2 got %h exp deadbeef", rg(5)); else passed++;
        checks++; if (commit_cnt !== 16'd1) $display("FAIL single_cnt got %0d exp 1", commit_cnt); else passed++;
    endtask

    task automatic test_stream();
        for (int i = 1; i <= 6; i++) begin
            bus.wvalid = 1'b1; bus.waddr = 5'(i); bus.wdata = 32'h100 + 32'(i);
            tick();
            checks++; if (bus.wready !== 1'b1) $display("FAIL stream_wready%0d got %b exp 1", i, bus.wready); else passed++;
            checks++; if (pending !== (BYP ? 2'd0 : 2'd1)) $display("FAIL stream_pending%0d got %0d exp %0d", i, pending, BYP ? 0 : 1); else passed++;
        end
        bus.wvalid = 1'b0;
        tick();
        for (int i = 1; i <= 6; i++) begin
            checks++; if (rg(i) !== 32'h100 + 32'(i)) $display("FAIL stream_reg%0d got %h exp %h", i, rg(i), 32'h100 + 32'(i)); else passed++;
        end
        checks++; if (commit_cnt !== 16'd7) $display("FAIL stream_cnt got %0d exp 7", commit_cnt); else passed++;
        checks++; if (pending !== 2'd0) $display("FAIL stream_drain got %0d exp 0", pending); else passed++;
    endtask

    task automatic test_zero_addr();
        bus.wvalid = 1'b1; bus.waddr = 5'd0; bus.wdata = 32'hFFFFFFFF;
        tick();
        checks++; if (pending !== (BYP ? 2'd0 : 2'd1)) $display("FAIL zero_accept got %0d exp %0d", pending, BYP ? 0 : 1); else passed++;
        bus.waddr = 5'd3; bus.wdata = 32'h12;
        tick();
        bus.wvalid = 1'b0;
        tick();
        checks++; if (rg(0) !== 32'h0) $display("FAIL zero_reg0 got %h exp 0", rg(0)); else passed++;
        checks++; if (rg(3) !== 32'h12) $display("FAIL zero_reg3 got %h exp 12", rg(3)); else passed++;
        checks++; if (commit_cnt !== 16'd8) $display("FAIL zero_cnt got %0d exp 8", commit_cnt); else passed++;
    endtask

    task automatic test_flush();
        logic [31:0] exp7;
        logic [15:0] expc;
        exp7 = BYP ? 32'hBBBB0002 : 32'hAAAA0001;
        expc = BYP ? 16'd10 : 16'd9;
        bus.wvalid = 1'b1; bus.waddr = 5'd7; bus.wdata = 32'hAAAA0001;
        tick();
        bus.wdata = 32'hBBBB0002;
        tick();
        checks++; if (rg(7) !== exp7) $display("FAIL flush_pre got %h exp %h", rg(7), exp7); else passed++;
        // request presented together with flush must be dropped
        bus.wdata = 32'hCCCC0003;
        flush = 1'b1;
        tick();
        flush = 1'b0; bus.wvalid = 1'b0;
        checks++; if (pending !== 2'd0) $display("FAIL flush_pending got %0d exp 0", pending); else passed++;
        checks++; if (rg(7) !== exp7) $display("FAIL flush_edge got %h exp %h", rg(7), exp7); else passed++;
        tick();
        checks++; if (rg(7) !== exp7) $display("FAIL flush_after got %h exp %h", rg(7), exp7); else passed++;
        checks++; if (commit_cnt !== expc) $display("FAIL flush_cnt got %0d exp %0d", commit_cnt, expc); else passed++;
    endtask

    task automatic test_reset_mid();
        bus.wvalid = 1'b1; bus.waddr = 5'd9; bus.wdata = 32'h99;
        tick();
        bus.waddr = 5'd4; bus.wdata = 32'h44;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (regs_flat !== '0) $display("FAIL rstmid_regs got %h exp 0", regs_flat[383:0]); else passed++;
        checks++; if (pending !== 2'd0) $display("FAIL rstmid_pending got %0d exp 0", pending); else passed++;
        checks++; if (commit_cnt !== 16'd0) $display("FAIL rstmid_cnt got %0d exp 0", commit_cnt); else passed++;
        checks++; if (bus.wready !== 1'b1) $display("FAIL rstmid_wready got %b exp 1", bus.wready); else passed++;
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        checks++; if (pending !== (BYP ? 2'd0 : 2'd1)) $display("FAIL firstedge_pending got %0d exp %0d", pending, BYP ? 0 : 1); else passed++;
        tick();
        checks++; if (rg(4) !== 32'h44) $display("FAIL firstedge_reg4 got %h exp 44", rg(4)); else passed++;
        checks++; if (rg(9) !== 32'h0) $display("FAIL rstmid_reg9 got %h exp 0", rg(9)); else passed++;
        checks++; if (commit_cnt !== 16'd1) $display("FAIL rstmid_cnt2 got %0d exp 1", commit_cnt); else passed++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 65534; i++) begin
            bus.wvalid = 1'b1; bus.waddr = 5'd1; bus.wdata = 32'(i);
            tick();
        end
        bus.wvalid = 1'b0;
        tick();
        checks++; if (commit_cnt !== 16'hFFFF) $display("FAIL wrap_pre got %h exp ffff", commit_cnt); else passed++;
        checks++; if (rg(1) !== 32'd65533) $display("FAIL wrap_data got %h exp %h", rg(1), 32'd65533); else passed++;
        bus.wvalid = 1'b1; bus.waddr = 5'd2; bus.wdata = 32'h5A5A;
        tick();
        bus.wvalid = 1'b0;
        tick();
        checks++; if (commit_cnt !== 16'h0000) $display("FAIL wrap_cnt got %h exp 0000", commit_cnt); else passed++;
        checks++; if (rg(2) !== 32'h5A5A) $display("FAIL wrap_reg2 got %h exp 5a5a", rg(2)); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_zero_addr();
        test_flush();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
